// File: rtl/usr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : usr_pkg                                                 |
// | Description : Shared types and helpers for universal_shift_reg.       |
// |               mode_t : 3-bit operation select (fully decoded)         |
// |               cnt_w  : width of a counter that must reach WIDTH       |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
package usr_pkg;

   typedef enum logic [2:0] {
      HOLD   = 3'd0,
      LOAD   = 3'd1,
      SHL    = 3'd2,
      SHR    = 3'd3,
      ROL    = 3'd4,
      ROR    = 3'd5,
      CLEAR  = 3'd6,
      INVERT = 3'd7
   } mode_t;

   // Bits needed to hold the value WIDTH itself (not just WIDTH-1).
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/shift_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shift_cnt                                               |
// | Description : Saturating shift counter with registered done flag.    |
// |   clk   in   rising-edge clock                                        |
// |   reset in   synchronous active-high reset                            |
// |   clr   in   return count to zero (wins over inc)                     |
// |   inc   in   count one shift, saturating at MAX                       |
// |   cnt   out  current count                                           |
// |   done  out  high while cnt == MAX                                    |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module shift_cnt
   import usr_pkg::*;
#(
   parameter int MAX = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clr,
   input  logic                    inc,
   output logic [cnt_w(MAX)-1:0]   cnt,
   output logic                    done
);

   localparam int            c_CW  = cnt_w(MAX);
   localparam logic [c_CW-1:0] c_MAX = c_CW'(MAX);

   logic [c_CW-1:0] r_cnt;
   logic            r_done;
   logic [c_CW-1:0] w_cnt_nxt;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (clr) begin
         w_cnt_nxt = '0;
      end else if (inc && (r_cnt != c_MAX)) begin
         w_cnt_nxt = r_cnt + c_CW'(1);
      end
   end

   // done is derived from the next count so it rises on the same edge
   // that the count reaches MAX, while still being a flop output.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_done <= (w_cnt_nxt == c_MAX);
      end
   end

   assign cnt  = r_cnt;
   assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/universal_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : universal_shift_reg                                     |
// | Description : WIDTH-bit universal shift register with eight modes,    |
// |               complementary outputs, serial taps and a saturating     |
// |               shift counter for PISO/SIPO use.                        |
// |   clk    in   rising-edge clock                                       |
// |   reset  in   synchronous active-high reset (overrides en/mode)       |
// |   en     in   clock enable, 0 freezes all state                       |
// |   mode   in   operation select (mode_t)                               |
// |   D      in   parallel load data                                      |
// |   sin_l  in   serial in, enters bit 0 on SHL                          |
// |   sin_r  in   serial in, enters bit WIDTH-1 on SHR                    |
// |   Q/Qn   out  register contents and its complement                    |
// |   sout_l out  Q[WIDTH-1]      sout_r out  Q[0]                        |
// |   cnt    out  shifts/rotates since LOAD/CLEAR, saturating at WIDTH    |
// |   done   out  high while cnt == WIDTH                                 |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module universal_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  mode_t                     mode,
   input  logic [WIDTH-1:0]          D,
   input  logic                      sin_l,
   input  logic                      sin_r,
   output logic [WIDTH-1:0]          Q,
   output logic [WIDTH-1:0]          Qn,
   output logic                      sout_l,
   output logic                      sout_r,
   output logic [cnt_w(WIDTH)-1:0]   cnt,
   output logic                      done
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_clr;
   logic             w_inc;

   always_comb begin
      w_q_nxt = r_q;
      case (mode)
         HOLD:    w_q_nxt = r_q;
         LOAD:    w_q_nxt = D;
         SHL:     w_q_nxt = {r_q[WIDTH-2:0], sin_l};
         SHR:     w_q_nxt = {sin_r, r_q[WIDTH-1:1]};
         ROL:     w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
         ROR:     w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
         CLEAR:   w_q_nxt = '0;
         INVERT:  w_q_nxt = ~r_q;
         default: w_q_nxt = r_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= RESET_VAL;
      end else if (en) begin
         r_q <= w_q_nxt;
      end
   end

   assign w_clr = en & ((mode == LOAD) | (mode == CLEAR));
   assign w_inc = en & ((mode == SHL) | (mode == SHR) |
                        (mode == ROL) | (mode == ROR));

   shift_cnt #(
      .MAX (WIDTH)
   ) u_shift_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (w_clr),
      .inc   (w_inc),
      .cnt   (cnt),
      .done  (done)
   );

   // Qn is a pure complement of the single stored copy, so Q and Qn can
   // never disagree, even across reset.
   assign Q      = r_q;
   assign Qn     = ~r_q;
   assign sout_l = r_q[WIDTH-1];
   assign sout_r = r_q[0];

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_universal_shift_reg                                  |
// | Description : Self-checking bench for universal_shift_reg (WIDTH=8,   |
// |               RESET_VAL=8'hA5). Expected state is pushed to a queue   |
// |               when stimulus is driven and popped after the edge.      |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module tb_universal_shift_reg;
   import usr_pkg::*;

   localparam int         c_W   = 8;
   localparam logic [7:0] c_RST = 8'hA5;

   typedef struct {
      logic [7:0] q;
      logic [3:0] cnt;
      logic       done;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       en;
   mode_t      mode;
   logic [7:0] D;
   logic       sin_l;
   logic       sin_r;
   logic [7:0] Q;
   logic [7:0] Qn;
   logic       sout_l;
   logic       sout_r;
   logic [3:0] cnt;
   logic       done;

   int n_vec = 0;
   int n_err = 0;

   exp_t sb[$];

   // Reference state
   logic [7:0] m_q;
   logic [3:0] m_cnt;
   logic       m_done;

   universal_shift_reg #(
      .WIDTH     (c_W),
      .RESET_VAL (c_RST)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .mode   (mode),
      .D      (D),
      .sin_l  (sin_l),
      .sin_r  (sin_r),
      .Q      (Q),
      .Qn     (Qn),
      .sout_l (sout_l),
      .sout_r (sout_r),
      .cnt    (cnt),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic rs, input logic e, input mode_t m,
                       input logic [7:0] d, input logic sl, input logic sr);
      exp_t       x;
      logic [7:0] qn_exp;
      reset = rs; en = e; mode = m; D = d; sin_l = sl; sin_r = sr;
      if (rs) begin
         m_q = c_RST; m_cnt = 4'd0;
      end else if (e) begin
         case (m)
            LOAD:   begin m_q = d;                   m_cnt = 4'd0; end
            CLEAR:  begin m_q = 8'h00;               m_cnt = 4'd0; end
            SHL:    begin m_q = (m_q << 1) | {7'd0, sl};        m_cnt = (m_cnt < 4'd8) ? m_cnt + 4'd1 : 4'd8; end
            SHR:    begin m_q = (m_q >> 1) | {sr, 7'd0};        m_cnt = (m_cnt < 4'd8) ? m_cnt + 4'd1 : 4'd8; end
            ROL:    begin m_q = (m_q << 1) | (m_q >> 7);        m_cnt = (m_cnt < 4'd8) ? m_cnt + 4'd1 : 4'd8; end
            ROR:    begin m_q = (m_q >> 1) | (m_q << 7);        m_cnt = (m_cnt < 4'd8) ? m_cnt + 4'd1 : 4'd8; end
            INVERT: m_q = ~m_q;
            default: ;
         endcase
      end
      m_done = (m_cnt == 4'd8);
      x.q = m_q; x.cnt = m_cnt; x.done = m_done;
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      qn_exp = ~x.q;
      chk("Q",      {24'd0, Q},      {24'd0, x.q});
      chk("Qn",     {24'd0, Qn},     {24'd0, qn_exp});
      chk("cnt",    {28'd0, cnt},    {28'd0, x.cnt});
      chk("done",   {31'd0, done},   {31'd0, x.done});
      chk("sout_l", {31'd0, sout_l}, {31'd0, x.q[7]});
      chk("sout_r", {31'd0, sout_r}, {31'd0, x.q[0]});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] dat;
      m_q = 8'h00; m_cnt = 4'd0; m_done = 1'b0;
      reset = 1'b0; en = 1'b0; mode = HOLD; D = 8'h00; sin_l = 1'b0; sin_r = 1'b0;

      // Reset dominates en=1/LOAD
      step(1'b1, 1'b1, LOAD, 8'hFF, 1'b0, 1'b0);
      chk("rst_Q",    {24'd0, Q},  32'hA5);
      chk("rst_Qn",   {24'd0, Qn}, 32'h5A);
      chk("rst_cnt",  {28'd0, cnt}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);

      // Load + serialise out of sout_r
      dat = 8'b1011_0010;
      step(1'b0, 1'b1, LOAD, dat, 1'b0, 1'b0);
      chk("ser0", {31'd0, sout_r}, {31'd0, dat[0]});
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 1'b1, SHR, 8'h00, 1'b0, 1'b0);
         if (i < 8) chk("ser_bit", {31'd0, sout_r}, {31'd0, dat[i]});
         chk("ser_done", {31'd0, done}, (i == 8) ? 32'd1 : 32'd0);
      end
      chk("ser_Q", {24'd0, Q}, 32'h00);
      step(1'b0, 1'b1, SHR, 8'h00, 1'b0, 1'b0);
      chk("sat_cnt",  {28'd0, cnt},  32'd8);
      chk("sat_done", {31'd0, done}, 32'd1);

      // Rotate and invert
      step(1'b0, 1'b1, LOAD, 8'h81, 1'b0, 1'b0);
      step(1'b0, 1'b1, ROL,  8'h00, 1'b0, 1'b0);
      chk("rol_Q", {24'd0, Q}, 32'h03);
      step(1'b0, 1'b1, ROR,  8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b1, ROR,  8'h00, 1'b0, 1'b0);
      chk("ror_Q",   {24'd0, Q},   32'hC0);
      chk("ror_cnt", {28'd0, cnt}, 32'd3);
      step(1'b0, 1'b1, INVERT, 8'h00, 1'b0, 1'b0);
      chk("inv_Q",   {24'd0, Q},   32'h3F);
      chk("inv_Qn",  {24'd0, Qn},  32'hC0);
      chk("inv_cnt", {28'd0, cnt}, 32'd3);

      // Enable gating
      step(1'b0, 1'b1, LOAD, 8'h3C, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, SHL, 8'h00, 1'b1, 1'b0);
      chk("gate_Q",   {24'd0, Q},   32'h3C);
      chk("gate_cnt", {28'd0, cnt}, 32'd0);
      step(1'b0, 1'b1, SHL, 8'h00, 1'b1, 1'b0);
      chk("shl_Q", {24'd0, Q}, 32'h79);

      // Shift to done, then CLEAR drops everything on one edge
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, ROL, 8'h00, 1'b0, 1'b0);
      chk("pre_clr_done", {31'd0, done}, 32'd1);
      step(1'b0, 1'b1, CLEAR, 8'h00, 1'b0, 1'b0);
      chk("clr_Q",    {24'd0, Q},   32'h00);
      chk("clr_cnt",  {28'd0, cnt}, 32'd0);
      chk("clr_done", {31'd0, done}, 32'd0);

      // Reset mid-serialisation
      step(1'b0, 1'b1, LOAD, 8'hF0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, SHR, 8'h00, 1'b1, 1'b1);
      step(1'b1, 1'b1, SHR, 8'h00, 1'b1, 1'b1);
      chk("mid_rst_Q",   {24'd0, Q},   32'hA5);
      chk("mid_rst_cnt", {28'd0, cnt}, 32'd0);

      // Random mix against the reference model
      for (int i = 0; i < 200; i++) begin
         step(($urandom_range(0, 23) == 0), ($urandom_range(0, 4) != 0),
              mode_t'($urandom_range(0, 7)), 8'($urandom),
              1'($urandom), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
